// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle for the digit-serial packed-BCD adder.
// The sub line exists only when BCD_SUB_EN is defined.
interface bcd_serial_adder_if #(parameter int DIGITS = 4);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
`ifdef BCD_SUB_EN
  logic                  sub;
`endif
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
`ifdef BCD_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  sum, cout, busy, done, err
  );

  modport slave (
`ifdef BCD_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output sum, cout, busy, done, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, LSB first, registered carry.
// Define BCD_SUB_EN to add nines-complement subtraction selected by the sub line.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input logic             clk,
  input logic             rst,
  bcd_serial_adder_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, FIN = 2'd2} state_t;

  state_t          state;
  state_t          state_next;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    sum_q;
  logic [W+3:0]    sum_cat;
  logic [CW-1:0]   idx;
  logic            carry;
  logic            cout_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            sub_q;
  logic [3:0]      a_d;
  logic [3:0]      b_raw;
  logic [3:0]      b_d;
  logic [3:0]      digit;
  logic [4:0]      t;
  logic            digit_carry;
  logic            digit_err;

`ifndef BCD_SUB_EN
  assign sub_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = ADD;
      ADD:     if (idx == LAST) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One-digit decimal-correct stage; invalid digits still follow the same +6 rule.
  always_comb begin
    a_d         = a_sh[3:0];
    b_raw       = b_sh[3:0];
    b_d         = sub_q ? (4'd9 - b_raw) : b_raw;
    t           = {1'b0, a_d} + {1'b0, b_d} + {4'd0, carry};
    digit_carry = (t > 5'd9);
    digit       = digit_carry ? (t[3:0] + 4'd6) : t[3:0];
    digit_err   = (a_d > 4'd9) || (b_raw > 4'd9);
    sum_cat     = {digit, sum_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            idx    <= '0;
            busy_q <= 1'b1;
            err_q  <= 1'b0;
`ifdef BCD_SUB_EN
            sub_q  <= bus.sub;
            carry  <= bus.sub ? 1'b1 : bus.cin;
`else
            carry  <= bus.cin;
`endif
          end
        end
        ADD: begin
          // Result digits enter from the top so digit 0 lands in [3:0] after DIGITS shifts.
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          sum_q <= sum_cat[W+3:4];
          carry <= digit_carry;
          idx   <= idx + 1'b1;
          if (digit_err) err_q <= 1'b1;
        end
        FIN: begin
          cout_q <= carry;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomized self-checking bench for bcd_serial_adder against a decimal-arithmetic reference.
// Subtraction vectors run only when BCD_SUB_EN is defined.
module tb_bcd_serial_adder;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
`ifdef BCD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int k = DIGITS - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] s = '0;
    int r = v;
    for (int k = 0; k < DIGITS; k++) begin
      s[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return s;
  endfunction

  // Valid operands use whole-number decimal arithmetic; invalid digits use the digit rule.
  function automatic void refModel(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv, input logic sv,
                                   output logic [W-1:0] s, output logic co, output logic er);
    int pow = 1;
    int ai, bi, total, c, ad, bd, tv;
    er = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      pow = pow * 10;
      if (av[4*k +: 4] > 4'd9 || bv[4*k +: 4] > 4'd9) er = 1'b1;
    end
    s = '0;
    if (!er) begin
      ai = bcd2int(av);
      bi = bcd2int(bv);
      if (sv) begin
        co = (ai >= bi);
        s  = co ? int2bcd(ai - bi) : int2bcd(pow - (bi - ai));
      end else begin
        total = ai + bi + int'(cv);
        co = (total >= pow);
        s  = int2bcd(total % pow);
      end
    end else begin
      c = sv ? 1 : int'(cv);
      for (int k = 0; k < DIGITS; k++) begin
        ad = int'(av[4*k +: 4]);
        bd = int'(bv[4*k +: 4]);
        if (sv) bd = (9 - bd) & 15;
        tv = ad + bd + c;
        if (tv > 9) begin
          s[4*k +: 4] = 4'((tv + 6) % 16);
          c = 1;
        end else begin
          s[4*k +: 4] = 4'(tv);
          c = 0;
        end
      end
      co = (c != 0);
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle in which done is high.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv, input logic sv);
    logic [W-1:0] esum;
    logic ecout, eerr;
    int cycles, busy_cnt;
    refModel(av, bv, cv, sv, esum, ecout, eerr);
    bus.a = av;
    bus.b = bv;
    bus.cin = cv;
`ifdef BCD_SUB_EN
    bus.sub = sv;
`endif
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.cin = 1'($urandom);
    busy_cnt = bus.busy ? 1 : 0;
    cycles = 0;
    while (!bus.done && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.busy) busy_cnt++;
    end
    checkOutput("latency", 32'(cycles), 32'(DIGITS + 1));
    checkOutput("busy_len", 32'(busy_cnt), 32'(DIGITS + 1));
    checkOutput("sum", 32'(bus.sum), 32'(esum));
    checkOutput("cout", 32'(bus.cout), 32'(ecout));
    checkOutput("err", 32'(bus.err), 32'(eerr));
  endtask

  initial begin
    logic [W-1:0] av, bv;
    logic cv, sv;
    int done_cnt;

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
`ifdef BCD_SUB_EN
    bus.sub = 1'b0;
`endif
    @(posedge clk); #1;
    checkOutput("rst_sum", 32'(bus.sum), 32'h0);
    checkOutput("rst_cout", 32'(bus.cout), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_done", 32'(bus.done), 32'h0);
    checkOutput("rst_err", 32'(bus.err), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(16'h1234, 16'h8766, 1'b0, 1'b0);
    checkOutput("tp1_sum", 32'(bus.sum), 32'h0000);
    checkOutput("tp1_cout", 32'(bus.cout), 32'h1);
    @(posedge clk); #1;
    checkOutput("done_pulse", 32'(bus.done), 32'h0);

    applyStimulus(16'h0999, 16'h0001, 1'b1, 1'b0);
    checkOutput("tp2a_sum", 32'(bus.sum), 32'h1001);
    applyStimulus(16'h9999, 16'h9999, 1'b1, 1'b0);
    checkOutput("tp2b_sum", 32'(bus.sum), 32'h9999);
    checkOutput("tp2b_cout", 32'(bus.cout), 32'h1);

    applyStimulus(16'h00A0, 16'h0005, 1'b0, 1'b0);
    checkOutput("tp3_sum", 32'(bus.sum), 32'h0105);
    checkOutput("tp3_err", 32'(bus.err), 32'h1);
    applyStimulus(16'h0042, 16'h0017, 1'b0, 1'b0);
    checkOutput("tp3_errclr", 32'(bus.err), 32'h0);

    // A second start during ADD must be dropped.
    bus.a = 16'h1234; bus.b = 16'h8766; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.a = 16'h5555; bus.b = 16'h1111; bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        done_cnt++;
        checkOutput("tp4_sum", 32'(bus.sum), 32'h0000);
        checkOutput("tp4_cout", 32'(bus.cout), 32'h1);
      end
    end
    checkOutput("tp4_dones", 32'(done_cnt), 32'h1);

    // Asynchronous reset while digit 2 is in flight.
    bus.a = 16'h4321; bus.b = 16'h1111; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("tp5_sum", 32'(bus.sum), 32'h0);
    checkOutput("tp5_cout", 32'(bus.cout), 32'h0);
    checkOutput("tp5_busy", 32'(bus.busy), 32'h0);
    checkOutput("tp5_done", 32'(bus.done), 32'h0);
    checkOutput("tp5_err", 32'(bus.err), 32'h0);
    #1 rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    checkOutput("tp5_nodone", 32'(done_cnt), 32'h0);
    applyStimulus(16'h4321, 16'h1111, 1'b0, 1'b0);
    checkOutput("tp5_after", 32'(bus.sum), 32'h5432);

    if (SUB_EN) begin
      applyStimulus(16'h5000, 16'h1234, 1'b0, 1'b1);
      checkOutput("tp6a_sum", 32'(bus.sum), 32'h3766);
      checkOutput("tp6a_cout", 32'(bus.cout), 32'h1);
      applyStimulus(16'h1234, 16'h5000, 1'b1, 1'b1);
      checkOutput("tp6b_sum", 32'(bus.sum), 32'h6234);
      checkOutput("tp6b_cout", 32'(bus.cout), 32'h0);
    end

    for (int i = 0; i < 40; i++) begin
      av = int2bcd(int'($urandom_range(0, 9999)));
      bv = int2bcd(int'($urandom_range(0, 9999)));
      if ($urandom_range(0, 4) == 0) av[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 6) == 0) bv[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      cv = 1'($urandom);
      sv = SUB_EN ? 1'($urandom) : 1'b0;
      applyStimulus(av, bv, cv, sv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
